// File: rtl/iq_decim_avg.sv
// Boxcar average-and-dump I/Q decimator feeding a 2-entry valid/ready output buffer.
// Define IQ_DECIM_ROUND_EN for round-half-up scaling; otherwise results truncate toward -inf.
module iq_decim_avg #(
    parameter int MAX_LOG2  = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic        adc_clk,
    input  logic        adc_rstn,
    input  logic        cfg_enable,
    input  logic [3:0]  cfg_decim_log2,
    input  logic        cfg_ovf_clr,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_ovf
);
    localparam int ACC_W = 16 + MAX_LOG2;
    localparam logic [3:0] MAX_L = 4'(MAX_LOG2);
    localparam logic [CNT_WIDTH:0] CNT_ONE = 1;

    logic [3:0] lat_log2, cfg_l, cur_l;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH:0] last_idx;
    logic signed [ACC_W-1:0] acc_i, acc_q, samp_i, samp_q, base_i, base_q;
    logic signed [ACC_W-1:0] part_i, part_q, sum_i, sum_q, shf_i, shf_q;
    logic accept, block_done, pop, full, drop;
    logic [31:0] res, slot0, slot1;
    logic [1:0] count;

    assign cfg_l  = (cfg_decim_log2 > MAX_L) ? MAX_L : cfg_decim_log2;
    // The first sample of a block already uses the newly sampled L.
    assign cur_l  = (cnt == '0) ? cfg_l : lat_log2;
    assign accept = cfg_enable & in_valid;

    assign last_idx   = (CNT_ONE << cur_l) - CNT_ONE;
    assign block_done = accept && ({1'b0, cnt} == last_idx);

    assign samp_i = {{MAX_LOG2{in_data[15]}}, in_data[15:0]};
    assign samp_q = {{MAX_LOG2{in_data[31]}}, in_data[31:16]};
    assign base_i = (cnt == '0) ? '0 : acc_i;
    assign base_q = (cnt == '0) ? '0 : acc_q;
    assign part_i = base_i + samp_i;
    assign part_q = base_q + samp_q;

`ifdef IQ_DECIM_ROUND_EN
    localparam logic signed [ACC_W-1:0] ACC_ONE = 1;
    logic signed [ACC_W-1:0] rnd;
    assign rnd   = (cur_l == 4'd0) ? '0 : (ACC_ONE << (cur_l - 4'd1));
    assign sum_i = part_i + rnd;
    assign sum_q = part_q + rnd;
`else
    assign sum_i = part_i;
    assign sum_q = part_q;
`endif

    assign shf_i = sum_i >>> cur_l;
    assign shf_q = sum_q >>> cur_l;
    assign res   = {shf_q[15:0], shf_i[15:0]};

    assign out_valid = (count != 2'd0);
    assign out_data  = slot0;
    assign pop       = out_valid & out_ready;
    assign full      = (count == 2'd2);
    assign drop      = block_done & full & ~pop;

    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) begin
            lat_log2 <= '0;
            cnt      <= '0;
            acc_i    <= '0;
            acc_q    <= '0;
        end else if (!cfg_enable) begin
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
        end else if (accept) begin
            if (cnt == '0)
                lat_log2 <= cfg_l;
            cnt   <= block_done ? '0 : cnt + 1'b1;
            acc_i <= part_i;
            acc_q <= part_q;
        end
    end

    // slot0 is always the head; a pop shifts slot1 forward before any push lands.
    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
            out_ovf <= 1'b0;
        end else begin
            case (count)
                2'd0: if (block_done) begin
                    slot0 <= res;
                    count <= 2'd1;
                end
                2'd1: begin
                    if (block_done && pop) slot0 <= res;
                    else if (block_done) begin
                        slot1 <= res;
                        count <= 2'd2;
                    end else if (pop) count <= 2'd0;
                end
                default: begin
                    if (pop) begin
                        slot0 <= slot1;
                        if (block_done) slot1 <= res;
                        else count <= 2'd1;
                    end
                end
            endcase
            if (drop) out_ovf <= 1'b1;
            else if (cfg_ovf_clr) out_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_iq_decim_avg.sv
// Directed bench for iq_decim_avg: pass-through, averaging, full scale, clamp,
// backpressure/overflow, disable mid-block and reset mid-block.
module tb_iq_decim_avg;
    logic        adc_clk = 1'b0;
    logic        adc_rstn;
    logic        cfg_enable;
    logic [3:0]  cfg_decim_log2;
    logic        cfg_ovf_clr;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_ovf;

    int total = 0;
    int bad   = 0;

    iq_decim_avg #(.MAX_LOG2(8), .CNT_WIDTH(8)) dut (
        .adc_clk(adc_clk), .adc_rstn(adc_rstn), .cfg_enable(cfg_enable),
        .cfg_decim_log2(cfg_decim_log2), .cfg_ovf_clr(cfg_ovf_clr),
        .in_data(in_data), .in_valid(in_valid), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ovf(out_ovf)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
    endtask

    logic [31:0] avg_exp;

    initial begin
`ifdef IQ_DECIM_ROUND_EN
        avg_exp = 32'hFFFC_000A;
`else
        avg_exp = 32'hFFFB_000A;
`endif
        adc_rstn = 1'b0; cfg_enable = 1'b0; cfg_decim_log2 = 4'd0; cfg_ovf_clr = 1'b0;
        in_data = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);

        // pass-through, L=0
        adc_rstn = 1'b1; cfg_enable = 1'b1; out_ready = 1'b1;
        send(32'h7FF0_8010); chk("pt0", out_data, 32'h7FF0_8010);
        chk("pt0_valid", 32'(out_valid), 32'd1);
        send(32'h0000_0002); chk("pt1", out_data, 32'h0000_0002);
        send(32'hFFFE_0004); chk("pt2", out_data, 32'hFFFE_0004);
        in_valid = 1'b0; tick();
        chk("pt_drained", 32'(out_valid), 32'd0);

        // L=2 average; cfg change after the first sample must not affect this block
        cfg_decim_log2 = 4'd2;
        send(32'hFFFC_0004);
        cfg_decim_log2 = 4'd3;
        send(32'hFFFC_0008);
        send(32'hFFFC_000C); chk("avg_wait", 32'(out_valid), 32'd0);
        send(32'hFFFB_0011); chk("avg_valid", 32'(out_valid), 32'd1);
        chk("avg_data", out_data, avg_exp);
        in_valid = 1'b0; tick();

        // full scale, L=8
        cfg_decim_log2 = 4'd8;
        for (int k = 0; k < 255; k++) send(32'h8000_7FFF);
        chk("fs_wait", 32'(out_valid), 32'd0);
        send(32'h8000_7FFF);
        chk("fs_data", out_data, 32'h8000_7FFF);
        in_valid = 1'b0; tick();

        // out-of-range L clamps to 8
        cfg_decim_log2 = 4'hF;
        for (int k = 0; k < 255; k++) send(32'hFF00_0100);
        chk("clamp_wait", 32'(out_valid), 32'd0);
        send(32'hFF00_0100);
        chk("clamp_data", out_data, 32'hFF00_0100);
        in_valid = 1'b0; tick();

        // backpressure and overflow, L=0
        cfg_decim_log2 = 4'd0; out_ready = 1'b0;
        send(32'h1111_2222);
        send(32'h3333_4444); chk("bp_noovf", 32'(out_ovf), 32'd0);
        send(32'h5555_6666); chk("bp_ovf", 32'(out_ovf), 32'd1);
        chk("bp_head", out_data, 32'h1111_2222);
        in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("bp_b", out_data, 32'h3333_4444);
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_ovf_sticky", 32'(out_ovf), 32'd1);
        cfg_ovf_clr = 1'b1; tick(); cfg_ovf_clr = 1'b0;
        chk("ovf_clr", 32'(out_ovf), 32'd0);

        // set wins over clear, then full buffer with simultaneous pop
        out_ready = 1'b0;
        send(32'hD0D0_D0D0);
        send(32'hE0E0_E0E0);
        cfg_ovf_clr = 1'b1; send(32'hF0F0_F0F0); cfg_ovf_clr = 1'b0;
        chk("set_wins", 32'(out_ovf), 32'd1);
        in_valid = 1'b0; cfg_ovf_clr = 1'b1; tick(); cfg_ovf_clr = 1'b0;
        chk("ovf_clr2", 32'(out_ovf), 32'd0);
        chk("hold_head", out_data, 32'hD0D0_D0D0);
        out_ready = 1'b1;
        send(32'h6060_6060);
        chk("fullpop_ovf", 32'(out_ovf), 32'd0);
        chk("fullpop_e", out_data, 32'hE0E0_E0E0);
        in_valid = 1'b0; tick();
        chk("fullpop_g", out_data, 32'h6060_6060);
        tick();
        chk("fullpop_empty", 32'(out_valid), 32'd0);

        // partial block discarded by disable, then L=1
        cfg_decim_log2 = 4'd2;
        send(32'h0100_0100);
        send(32'h0100_0100);
        cfg_enable = 1'b0; send(32'h0100_0100);
        chk("dis_novalid", 32'(out_valid), 32'd0);
        cfg_enable = 1'b1; cfg_decim_log2 = 4'd1;
        send(32'h0006_0002); chk("reen_wait", 32'(out_valid), 32'd0);
        send(32'h0008_0004); chk("reen_valid", 32'(out_valid), 32'd1);
        chk("reen_data", out_data, 32'h0007_0003);
        in_valid = 1'b0; tick();

        // reset mid-block with a buffered result pending
        cfg_decim_log2 = 4'd0; out_ready = 1'b0;
        send(32'hAAAA_5555);
        cfg_decim_log2 = 4'd2;
        send(32'h0001_0001);
        in_valid = 1'b0; adc_rstn = 1'b0; tick();
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_data", out_data, 32'h0);
        adc_rstn = 1'b1;
        send(32'h0004_0004);
        send(32'h0004_0004);
        send(32'h0004_0004); chk("rst_fresh_wait", 32'(out_valid), 32'd0);
        send(32'h0004_0004); chk("rst_fresh_data", out_data, 32'h0004_0004);
        in_valid = 1'b0; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
